// File: rtl/mem_access_stage.sv
// mem_access_stage
//   MEM pipeline stage of the MIPS pipelined core. Performs word/byte loads
//   and stores against an internal 32-bit data RAM. Each access adds
//   WAIT_CYCLES stall cycles, and the stall holds the upstream stages. The
//   stage also registers the MEM/WB pipeline outputs that feed write-back.
//
// Parameters
//   ADDR_WIDTH   word-address width; RAM depth = 2**ADDR_WIDTH words
//   WAIT_CYCLES  stall cycles added per load/store (0..15)
//
// Ports
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   EXE_MEM_*           EXE/MEM register outputs (held stable while stalled)
//   MEM_Stall           combinational stall for EXE/MEM and earlier stages
//   MEM_WB_*            registered MEM/WB outputs
//
// Build option
//   MEM_LB_SIGN_EXT_EN  defined: byte loads sign-extend from bit 7;
//                       undefined: byte loads zero-extend.

module mem_access_stage #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] EXE_MEM_Result,
  input  logic [31:0] EXE_MEM_Rt,
  input  logic [4:0]  EXE_MEM_DstReg,
  input  logic        EXE_MEM_MemRead,
  input  logic        EXE_MEM_MemWrite,
  input  logic        EXE_MEM_MemtoReg,
  input  logic        EXE_MEM_RegWrite,
  input  logic        EXE_MEM_Byte,
  input  logic        EXE_MEM_JmpandLink,
  output logic        MEM_Stall,
  output logic [31:0] MEM_WB_ReadData,
  output logic [31:0] MEM_WB_Result,
  output logic [4:0]  MEM_WB_DstReg,
  output logic        MEM_WB_MemtoReg,
  output logic        MEM_WB_RegWrite,
  output logic        MEM_WB_JmpandLink
);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  // The IDLE edge that accepts an access is itself a stall cycle, so the
  // counter starts one below the wait-state count.
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t                  state, state_next;
  logic [3:0]              cnt, cnt_next;
  logic                    stall;
  logic                    acc, is_store, is_load;
  logic [ADDR_WIDTH-1:0]   word_idx;
  logic [1:0]              lane;
  logic [31:0]             ram [2**ADDR_WIDTH];
  logic [31:0]             ram_word;
  logic [7:0]              lane_byte;
  logic [31:0]             load_data;

  // Read+write together behaves as a store and returns no load data.
  assign acc      = EXE_MEM_MemRead | EXE_MEM_MemWrite;
  assign is_store = EXE_MEM_MemWrite;
  assign is_load  = EXE_MEM_MemRead & ~EXE_MEM_MemWrite;
  assign word_idx = EXE_MEM_Result[ADDR_WIDTH+1:2];
  assign lane     = EXE_MEM_Result[1:0];

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    stall      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (acc && (WAIT_CYCLES != 0)) begin
          stall      = 1'b1;
          state_next = ST_WAIT;
          cnt_next   = CNT_INIT;
        end
      end
      ST_WAIT: begin
        if (cnt != 4'd0) begin
          stall    = 1'b1;
          cnt_next = cnt - 4'd1;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign MEM_Stall = stall & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // RAM has no reset; gating with rst means a store interrupted by reset
  // never lands, even when it would commit on the same edge.
  always_ff @(posedge clk) begin
    if (!rst && !stall && is_store) begin
      if (EXE_MEM_Byte) begin
        ram[word_idx][{lane, 3'b000} +: 8] <= EXE_MEM_Rt[7:0];
      end else begin
        ram[word_idx] <= EXE_MEM_Rt;
      end
    end
  end

  assign ram_word = ram[word_idx];

  always_comb begin
    lane_byte = ram_word[7:0];
    case (lane)
      2'd0: lane_byte = ram_word[7:0];
      2'd1: lane_byte = ram_word[15:8];
      2'd2: lane_byte = ram_word[23:16];
      2'd3: lane_byte = ram_word[31:24];
      default: lane_byte = ram_word[7:0];
    endcase
  end

  always_comb begin
    load_data = ram_word;
    if (EXE_MEM_Byte) begin
`ifdef MEM_LB_SIGN_EXT_EN
      load_data = {{24{lane_byte[7]}}, lane_byte};
`else
      load_data = {24'd0, lane_byte};
`endif
    end
  end

  // Stall edges push a bubble into write-back; commit edges capture the
  // instruction, with load data only for true loads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      MEM_WB_ReadData   <= 32'd0;
      MEM_WB_Result     <= 32'd0;
      MEM_WB_DstReg     <= 5'd0;
      MEM_WB_MemtoReg   <= 1'b0;
      MEM_WB_RegWrite   <= 1'b0;
      MEM_WB_JmpandLink <= 1'b0;
    end else if (stall) begin
      MEM_WB_ReadData   <= 32'd0;
      MEM_WB_Result     <= 32'd0;
      MEM_WB_DstReg     <= 5'd0;
      MEM_WB_MemtoReg   <= 1'b0;
      MEM_WB_RegWrite   <= 1'b0;
      MEM_WB_JmpandLink <= 1'b0;
    end else begin
      MEM_WB_ReadData   <= is_load ? load_data : 32'd0;
      MEM_WB_Result     <= EXE_MEM_Result;
      MEM_WB_DstReg     <= EXE_MEM_DstReg;
      MEM_WB_MemtoReg   <= EXE_MEM_MemtoReg;
      MEM_WB_RegWrite   <= EXE_MEM_RegWrite;
      MEM_WB_JmpandLink <= EXE_MEM_JmpandLink;
    end
  end

endmodule
